exec_sequencer: RTL and testbench

Run/halt/step controller for the single-cycle RV32I data path. Generates the two datapath clock-enable phases: clk_enable_n for the register-file/data-memory write phase, then clk_enable for the PC update phase. Pre-screens each fetched instruction and stops on EBREAK/ECALL or an illegal opcode. Provides single-step, external halt, an instruction budget, and retired-instruction and cycle counters for bring-up and test.

---
 rtl/exec_sequencer.sv | 158 +++++++++++++++
 tb/tb_exec_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Run/halt/step sequencer for the single-cycle RV32I datapath: screens each fetched
// instruction, then drives a write-back enable phase followed by a PC-update enable phase.
module exec_sequencer #(
    parameter int CNT_W         = 32,
    parameter bit START_RUNNING = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] instr_limit,
    input  logic [31:0]      instruction,
    output logic             clk_enable,
    output logic             clk_enable_n,
    output logic             running,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_CHK    = 2'd1,
        S_WB     = 2'd2,
        S_ADV    = 2'd3
    } state_t;

    localparam state_t RESET_STATE = START_RUNNING ? S_CHK : S_HALTED;

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_HALT  = 3'd1;
    localparam logic [2:0] CAUSE_TRAP  = 3'd2;
    localparam logic [2:0] CAUSE_ILLEG = 3'd3;
    localparam logic [2:0] CAUSE_LIMIT = 3'd4;
    localparam logic [2:0] CAUSE_STEP  = 3'd5;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

    // SYSTEM (1110011) is deliberately absent: only the exact EBREAK/ECALL encodings are accepted, and they trap.
    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       cause_q, cause_d;
    logic             pending_q, pending_d;
    logic             step_mode_q, step_mode_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_inc_s;

    assign retired_inc_s = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, halt-cause and counter update logic.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        pending_d   = pending_q;
        step_mode_d = step_mode_q;
        retired_d   = retired_q;
        if (state_q != S_HALTED) begin
            cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cycle_d = cycle_q;
        end
        case (state_q)
            S_HALTED: begin
                if (run) begin
                    state_d     = S_CHK;
                    step_mode_d = 1'b0;
                end else if (step) begin
                    state_d     = S_CHK;
                    step_mode_d = 1'b1;
                end else begin
                    state_d = S_HALTED;
                end
            end
            S_CHK: begin
                if ((instruction == INSTR_EBREAK) || (instruction == INSTR_ECALL)) begin
                    state_d   = S_HALTED;
                    cause_d   = CAUSE_TRAP;
                    pending_d = 1'b0;
                end else if (!opcode_legal(instruction[6:0])) begin
                    state_d   = S_HALTED;
                    cause_d   = CAUSE_ILLEG;
                    pending_d = 1'b0;
                end else begin
                    state_d   = S_WB;
                    pending_d = pending_q | halt_req;
                end
            end
            S_WB: begin
                state_d   = S_ADV;
                pending_d = pending_q | halt_req;
            end
            S_ADV: begin
                retired_d = retired_inc_s;
                if ((instr_limit != {CNT_W{1'b0}}) && (retired_inc_s == instr_limit)) begin
                    state_d   = S_HALTED;
                    cause_d   = CAUSE_LIMIT;
                    pending_d = 1'b0;
                end else if (pending_q || halt_req) begin
                    state_d   = S_HALTED;
                    cause_d   = CAUSE_HALT;
                    pending_d = 1'b0;
                end else if (step_mode_q) begin
                    state_d   = S_HALTED;
                    cause_d   = CAUSE_STEP;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_CHK;
                end
            end
            default: begin
                state_d   = S_HALTED;
                pending_d = 1'b0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any in-flight instruction immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            cause_q     <= CAUSE_RESET;
            pending_q   <= 1'b0;
            step_mode_q <= 1'b0;
            retired_q   <= {CNT_W{1'b0}};
            cycle_q     <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            pending_q   <= pending_d;
            step_mode_q <= step_mode_d;
            retired_q   <= retired_d;
            cycle_q     <= cycle_d;
        end
    end

    // Enables decode straight from the state register so they fall with reset asynchronously.
    assign clk_enable_n  = (state_q == S_WB);
    assign clk_enable    = (state_q == S_ADV);
    assign halted        = (state_q == S_HALTED);
    assign running       = (state_q != S_HALTED);
    assign halt_cause    = cause_q;
    assign retired_count = retired_q;
    assign cycle_count   = cycle_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer: free run, step, traps, limit, halt, reset, wrap.
module tb_exec_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0, step = 1'b0, halt_req = 1'b0;
    logic [31:0] instr_limit = 32'd0;
    logic [31:0] instruction = NOP;
    logic        clk_enable, clk_enable_n, running, halted;
    logic [2:0]  halt_cause;
    logic [31:0] retired_count, cycle_count;

    logic        run4 = 1'b0;
    logic        en4, en4_n, running4, halted4;
    logic [2:0]  cause4;
    logic [3:0]  retired4, cycle4;

    int n_checks = 0;
    int n_errors = 0;
    logic both_seen = 1'b0;

    always #5 clk = ~clk;

    exec_sequencer u_dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .halt_req(halt_req),
        .instr_limit(instr_limit), .instruction(instruction),
        .clk_enable(clk_enable), .clk_enable_n(clk_enable_n), .running(running),
        .halted(halted), .halt_cause(halt_cause), .retired_count(retired_count),
        .cycle_count(cycle_count)
    );

    exec_sequencer #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .run(run4), .step(1'b0), .halt_req(1'b0),
        .instr_limit(4'd0), .instruction(NOP),
        .clk_enable(en4), .clk_enable_n(en4_n), .running(running4),
        .halted(halted4), .halt_cause(cause4), .retired_count(retired4),
        .cycle_count(cycle4)
    );

    always @(negedge clk) begin
        if (clk_enable && clk_enable_n) both_seen <= 1'b1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic single_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        tick();
    endtask

    logic [31:0] trap_instr [4];
    logic [2:0]  trap_cause [4];
    logic [31:0] base;
    int          waited;

    initial begin
        trap_instr = '{32'h0010_0073, 32'h0000_0073, 32'h0000_007F, 32'h0000_1073};
        trap_cause = '{3'd2, 3'd2, 3'd3, 3'd3};

        do_reset();
        check_val("rst_halted", halted, 1);
        check_val("rst_running", running, 0);
        check_val("rst_en", {clk_enable, clk_enable_n}, 0);
        check_val("rst_cause", halt_cause, 0);
        check_val("rst_retired", retired_count, 0);
        check_val("rst_cycles", cycle_count, 0);
        check_val("rst4_halted", halted4, 1);

        // Free run of NOPs: phase pattern CHK, WB, ADV.
        run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_val($sformatf("run_en_n_%0d", k), clk_enable_n, (k % 3) == 2);
            check_val($sformatf("run_en_%0d", k), clk_enable, (k % 3) == 0);
        end
        run = 1'b0;
        check_val("run_retired", retired_count, 3);
        check_val("run_cycles", cycle_count, 9);
        check_val("run_running", running, 1);

        // halt_req in CHK: current instruction still retires, then halt.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        tick();
        check_val("hreq_halted", halted, 1);
        check_val("hreq_cause", halt_cause, 1);
        check_val("hreq_retired", retired_count, 4);

        // Single step.
        step = 1'b1;
        tick();
        step = 1'b0;
        check_val("step_chk_en", {clk_enable, clk_enable_n}, 0);
        tick();
        check_val("step_wb", {clk_enable, clk_enable_n}, 2'b01);
        tick();
        check_val("step_adv", {clk_enable, clk_enable_n}, 2'b10);
        tick();
        check_val("step_halted", halted, 1);
        check_val("step_cause", halt_cause, 5);
        check_val("step_retired", retired_count, 5);

        // Traps: no enables, no retire.
        for (int t = 0; t < 4; t++) begin
            base = retired_count;
            run = 1'b1;
            tick();
            run = 1'b0;
            instruction = trap_instr[t];
            tick();
            check_val($sformatf("trap%0d_halted", t), halted, 1);
            check_val($sformatf("trap%0d_en", t), {clk_enable, clk_enable_n}, 0);
            check_val($sformatf("trap%0d_cause", t), halt_cause, trap_cause[t]);
            check_val($sformatf("trap%0d_retired", t), retired_count, base);
            instruction = NOP;
        end

        // halt_req during a trapping CHK must not leave a stale pending halt.
        instruction = 32'h0010_0073;
        run = 1'b1;
        tick();
        run = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        instruction = NOP;
        check_val("trap_hreq_cause", halt_cause, 2);
        single_step();
        check_val("pend_clr_trap", halt_cause, 5);

        // halt_req while HALTED is ignored.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_val("hreq_idle_halted", halted, 1);
        single_step();
        check_val("hreq_idle_cause", halt_cause, 5);

        // Instruction budget of 5.
        do_reset();
        instr_limit = 32'd5;
        run = 1'b1;
        tick();
        run = 1'b0;
        waited = 0;
        while (!halted && waited < 40) begin
            tick();
            waited++;
        end
        check_val("lim_halted", halted, 1);
        check_val("lim_latency", waited, 15);
        check_val("lim_retired", retired_count, 5);
        check_val("lim_cause", halt_cause, 4);
        check_val("lim_cycles", cycle_count, 15);

        // Limit and halt_req on the same ADV: limit wins.
        do_reset();
        instr_limit = 32'd2;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_val("lh_in_wb", clk_enable_n, 1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check_val("lh_halted", halted, 1);
        check_val("lh_cause", halt_cause, 4);
        check_val("lh_retired", retired_count, 2);

        // halt_req in WB with no limit.
        instr_limit = 32'd0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check_val("hwb_halted", halted, 1);
        check_val("hwb_cause", halt_cause, 1);
        check_val("hwb_retired", retired_count, 3);

        // Reset mid-WB drops enables without waiting for a clock edge.
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check_val("ar_in_wb", clk_enable_n, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_val("ar_en_n", clk_enable_n, 0);
        check_val("ar_en", clk_enable, 0);
        check_val("ar_halted", halted, 1);
        check_val("ar_retired", retired_count, 0);
        check_val("ar_cycles", cycle_count, 0);
        check_val("ar_cause", halt_cause, 0);
        tick();
        reset_n = 1'b1;

        // 4-bit counters: 17 instructions wrap retired_count to 1.
        run4 = 1'b1;
        tick();
        run4 = 1'b0;
        for (int k = 0; k < 51; k++) tick();
        check_val("wrap_retired", retired4, 1);
        check_val("wrap_cycles", cycle4, 3);
        check_val("wrap_running", running4, 1);

        check_val("never_both_en", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
